// File: rtl/alu_seq_pkg.sv
// Shared types and code points for the ALU instruction sequencer:
// opcodes, bus select codes, FSM states and the registered control word.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_MOV  = 4'h0, OP_ADD  = 4'h1, OP_ADC  = 4'h2, OP_SUB  = 4'h3,
    OP_SBC  = 4'h4, OP_AND  = 4'h5, OP_OR   = 4'h6, OP_XOR  = 4'h7,
    OP_NOT  = 4'h8, OP_SHL  = 4'h9, OP_RLC  = 4'hA, OP_SWAP = 4'hB,
    OP_CMP  = 4'hC, OP_LDI  = 4'hD, OP_NOP  = 4'hE, OP_HALT = 4'hF
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE, ST_IMM, ST_EXEC, ST_HALT
  } state_e;

  localparam logic [3:0] OUT_FLAGS  = 4'd4;
  localparam logic [3:0] OUT_ADDSUB = 4'd5;
  localparam logic [3:0] OUT_ANDOR  = 4'd6;
  localparam logic [3:0] OUT_SHSW   = 4'd7;
  localparam logic [3:0] OUT_XORNOT = 4'd10;
  localparam logic [3:0] OUT_NONE   = 4'd15;

  localparam logic [3:0] LOAD_FLAGS = 4'd7;
  localparam logic [3:0] LOAD_NONE  = 4'd15;

  localparam logic [2:0] ARGR_ZERO  = 3'd6;
  localparam logic [2:0] ARGR_NONE  = 3'd7;

  typedef struct packed {
    logic [3:0] outctl;
    logic [3:0] loadctl;
    logic [1:0] arg_l;
    logic [2:0] arg_r;
    logic       alt;
    logic       calcfn;
    logic       cin;
    logic       bus_oe;
    logic [7:0] bus_out;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{
    outctl:  OUT_NONE,
    loadctl: LOAD_NONE,
    arg_l:   2'd0,
    arg_r:   ARGR_NONE,
    alt:     1'b0,
    calcfn:  1'b1,
    cin:     1'b0,
    bus_oe:  1'b0,
    bus_out: 8'h00
  };

endpackage

// File: rtl/alu_op_decode.sv
// Pure combinational opcode decode into the control word driven during EXEC.
module alu_op_decode
  import alu_seq_pkg::*;
(
  input  op_e        op,
  input  logic [1:0] dst,
  input  logic [1:0] src,
  input  logic [7:0] imm,
  input  logic       carry,
  output ctl_t       ctl
);

  ctl_t base;

  always_comb begin
    // Two-operand ALU form: dst op src -> dst, flags updated.
    base         = CTL_IDLE;
    base.arg_l   = dst;
    base.arg_r   = {1'b0, src};
    base.loadctl = {2'b00, dst};
    base.calcfn  = 1'b0;

    ctl = base;
    case (op)
      OP_MOV:  begin
        ctl.outctl = OUT_ADDSUB;
        ctl.arg_l  = src;
        ctl.arg_r  = ARGR_ZERO;
        ctl.calcfn = 1'b1;
      end
      OP_ADD:  ctl.outctl = OUT_ADDSUB;
      OP_ADC:  begin ctl.outctl = OUT_ADDSUB; ctl.cin = carry; end
      OP_SUB:  begin ctl.outctl = OUT_ADDSUB; ctl.alt = 1'b1; ctl.cin = 1'b1; end
      OP_SBC:  begin ctl.outctl = OUT_ADDSUB; ctl.alt = 1'b1; ctl.cin = carry; end
      OP_AND:  ctl.outctl = OUT_ANDOR;
      OP_OR:   begin ctl.outctl = OUT_ANDOR; ctl.alt = 1'b1; end
      OP_XOR:  ctl.outctl = OUT_XORNOT;
      OP_NOT:  begin
        ctl.outctl = OUT_XORNOT;
        ctl.alt    = 1'b1;
        ctl.arg_l  = src;
        ctl.arg_r  = ARGR_NONE;
      end
      OP_SHL:  begin ctl.outctl = OUT_SHSW; ctl.arg_r = ARGR_NONE; end
      OP_RLC:  begin ctl.outctl = OUT_SHSW; ctl.arg_r = ARGR_NONE; ctl.cin = carry; end
      OP_SWAP: begin
        ctl.outctl = OUT_SHSW;
        ctl.alt    = 1'b1;
        ctl.arg_r  = ARGR_NONE;
        ctl.calcfn = 1'b1;
      end
      // Compare runs the subtract path for flags only; no register write.
      OP_CMP:  begin
        ctl.outctl  = OUT_ADDSUB;
        ctl.alt     = 1'b1;
        ctl.cin     = 1'b1;
        ctl.loadctl = LOAD_NONE;
      end
      OP_LDI:  begin
        ctl.outctl  = OUT_NONE;
        ctl.bus_oe  = 1'b1;
        ctl.bus_out = imm;
        ctl.arg_r   = ARGR_NONE;
        ctl.calcfn  = 1'b1;
      end
      default: ctl = CTL_IDLE;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Byte-stream instruction sequencer: accepts opcode (+ optional immediate)
// bytes and drives one cycle of registered ALU/bus control per instruction.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] instr_data,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [3:0] fin,
  output logic [3:0] outctl,
  output logic [3:0] loadctl,
  output logic [1:0] arg_l,
  output logic [2:0] arg_r,
  output logic       alt,
  output logic       calcfn,
  output logic       cin,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       halted
);

  state_e     state, state_d;
  op_e        op_q, dec_op;
  logic [1:0] dst_q, src_q, dec_dst, dec_src;
  logic       accept;
  ctl_t       dec_ctl, ctl_d, ctl_q;

  assign instr_ready = (state == ST_IDLE) || (state == ST_IMM);
  assign accept      = instr_valid && instr_ready;

  // In IDLE the decode sees the incoming byte so a 1-byte op's controls
  // are registered on the same edge that accepts it.
  always_comb begin
    dec_op  = op_q;
    dec_dst = dst_q;
    dec_src = src_q;
    if (state == ST_IDLE) begin
      dec_op  = op_e'(instr_data[7:4]);
      dec_dst = instr_data[3:2];
      dec_src = instr_data[1:0];
    end
  end

  alu_op_decode u_dec (
    .op    (dec_op),
    .dst   (dec_dst),
    .src   (dec_src),
    .imm   (instr_data),
    .carry (fin[0]),
    .ctl   (dec_ctl)
  );

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: if (accept) begin
        case (op_e'(instr_data[7:4]))
          OP_LDI:  state_d = ST_IMM;
          OP_HALT: state_d = ST_HALT;
          default: state_d = ST_EXEC;
        endcase
      end
      ST_IMM:  if (accept) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_IDLE;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  assign ctl_d = (state_d == ST_EXEC) ? dec_ctl : CTL_IDLE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      op_q   <= OP_MOV;
      dst_q  <= 2'd0;
      src_q  <= 2'd0;
      ctl_q  <= CTL_IDLE;
      halted <= 1'b0;
    end else begin
      state  <= state_d;
      ctl_q  <= ctl_d;
      halted <= (state_d == ST_HALT);
      if (state == ST_IDLE && accept) begin
        op_q  <= op_e'(instr_data[7:4]);
        dst_q <= instr_data[3:2];
        src_q <= instr_data[1:0];
      end
    end
  end

  assign outctl  = ctl_q.outctl;
  assign loadctl = ctl_q.loadctl;
  assign arg_l   = ctl_q.arg_l;
  assign arg_r   = ctl_q.arg_r;
  assign alt     = ctl_q.alt;
  assign calcfn  = ctl_q.calcfn;
  assign cin     = ctl_q.cin;
  assign bus_oe  = ctl_q.bus_oe;
  assign bus_out = ctl_q.bus_out;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: hand-computed control words per opcode,
// LDI immediate path, ignored bytes in EXEC/HALT, async reset aborts.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] instr_data;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] fin;
  logic [3:0] outctl, loadctl;
  logic [1:0] arg_l;
  logic [2:0] arg_r;
  logic       alt, calcfn, cin, bus_oe, halted;
  logic [7:0] bus_out;

  int errors = 0;
  int checks = 0;

  alu_sequencer dut (
    .clk(clk), .rst(rst), .instr_data(instr_data), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .fin(fin), .outctl(outctl), .loadctl(loadctl),
    .arg_l(arg_l), .arg_r(arg_r), .alt(alt), .calcfn(calcfn), .cin(cin),
    .bus_out(bus_out), .bus_oe(bus_oe), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic ctl_t mk(input logic [3:0] oc, input logic [3:0] lc,
                              input logic [1:0] al, input logic [2:0] ar,
                              input logic a, input logic cf, input logic ci,
                              input logic oe, input logic [7:0] bo);
    ctl_t c;
    c = '{outctl: oc, loadctl: lc, arg_l: al, arg_r: ar, alt: a,
          calcfn: cf, cin: ci, bus_oe: oe, bus_out: bo};
    return c;
  endfunction

  function automatic ctl_t cur();
    return mk(outctl, loadctl, arg_l, arg_r, alt, calcfn, cin, bus_oe, bus_out);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; presents one byte across the next rising edge.
  task automatic send(input logic [7:0] b);
    instr_data  = b;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    instr_data  = 8'h00;
  endtask

  task automatic exec1(input string tag, input logic [7:0] b, input ctl_t exp);
    send(b);
    chk(tag, 32'(cur()), 32'(exp));
    chk({tag, "_ready_exec"}, 32'(instr_ready), 32'd0);
    @(negedge clk);
    chk({tag, "_idle_after"}, 32'(cur()), 32'(CTL_IDLE));
  endtask

  initial begin
    rst = 1'b0; instr_data = 8'h00; instr_valid = 1'b0; fin = 4'h0;
    repeat (3) @(negedge clk);
    chk("reset_ctl", 32'(cur()), 32'(CTL_IDLE));
    chk("reset_halted", 32'(halted), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(instr_ready), 32'd1);

    exec1("add_a_b", 8'h11, mk(4'd5, 4'd0, 2'd0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));

    // ADC carry is captured on the edge entering EXEC, not tracked afterwards.
    fin = 4'h1;
    instr_data = 8'h2B; instr_valid = 1'b1;
    @(posedge clk); #1 fin = 4'h0; instr_valid = 1'b0;
    @(negedge clk);
    chk("adc_cin1", 32'(cur()), 32'(mk(4'd5, 4'd2, 2'd2, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00)));
    @(negedge clk);
    exec1("adc_cin0", 8'h2B, mk(4'd5, 4'd2, 2'd2, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));

    // LDI B with a 3-cycle gap before the immediate.
    send(8'hD4);
    chk("ldi_imm_ready", 32'(instr_ready), 32'd1);
    chk("ldi_imm_ctl", 32'(cur()), 32'(CTL_IDLE));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ldi_gap_ready", 32'(instr_ready), 32'd1);
      chk("ldi_gap_ctl", 32'(cur()), 32'(CTL_IDLE));
    end
    instr_data = 8'h5A; instr_valid = 1'b1;
    @(negedge clk);
    chk("ldi_exec", 32'(cur()), 32'(mk(4'd15, 4'd1, 2'd1, 3'd7, 1'b0, 1'b1, 1'b0, 1'b1, 8'h5A)));
    // Byte offered during EXEC must not be consumed as an instruction there.
    instr_data = 8'h11;
    @(negedge clk);
    chk("exec_byte_ignored", 32'(cur()), 32'(CTL_IDLE));
    instr_valid = 1'b0; instr_data = 8'h00;
    @(negedge clk);
    chk("idle_ready", 32'(instr_ready), 32'd1);

    exec1("cmp_a_c", 8'hC2, mk(4'd5, 4'd15, 2'd0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00));
    exec1("sbc_b_c", 8'h46, mk(4'd5, 4'd1, 2'd1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00));
    exec1("mov_d_c", 8'h0E, mk(4'd5, 4'd3, 2'd2, 3'd6, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00));
    exec1("not_b_d", 8'h87, mk(4'd10, 4'd1, 2'd3, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00));
    exec1("or_c_b", 8'h69, mk(4'd6, 4'd2, 2'd2, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00));
    exec1("swap_b", 8'hB5, mk(4'd7, 4'd1, 2'd1, 3'd7, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00));
    fin = 4'h1;
    exec1("rlc_a", 8'hA0, mk(4'd7, 4'd0, 2'd0, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00));
    fin = 4'h0;
    exec1("nop", 8'hE5, CTL_IDLE);

    // Reset mid-EXEC drops controls to idle without waiting for a clock.
    send(8'h11);
    chk("pre_abort_add", 32'(cur()), 32'(mk(4'd5, 4'd0, 2'd0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00)));
    #2 rst = 1'b0;
    #1 chk("abort_exec_ctl", 32'(cur()), 32'(CTL_IDLE));
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    // Reset mid-IMM forgets the LDI; next byte is a fresh opcode.
    send(8'hD4);
    rst = 1'b0; #1 rst = 1'b1;
    exec1("after_imm_abort", 8'h11, mk(4'd5, 4'd0, 2'd0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));

    send(8'hF0);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_ready", 32'(instr_ready), 32'd0);
    instr_data = 8'h11; instr_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("halt_hold_flag", 32'(halted), 32'd1);
    chk("halt_hold_ready", 32'(instr_ready), 32'd0);
    chk("halt_hold_ctl", 32'(cur()), 32'(CTL_IDLE));
    instr_valid = 1'b0; instr_data = 8'h00;
    rst = 1'b0;
    #1 chk("halt_cleared", 32'(halted), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("ready_after_halt_reset", 32'(instr_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have port: clk  in  1  single system clock; all state on rising edge.
REQ-002 SHALL have port: rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port: instr_data  in  8  instruction byte {op[7:4], dst[3:2], src[1:0]} or immediate byte.
REQ-004 SHALL have port: instr_valid  in  1  instr_data valid.
REQ-005 SHALL have port: instr_ready  out  1  sequencer accepts a byte; transfer when valid & ready at clk edge.
REQ-006 SHALL have port: fin  in  4  flags from ALU block; fin[0] = carry.
REQ-007 SHALL have port: outctl  out  4  bus-output select; 0-3 regs A-D, 4 flags, 5 addsub, 6 andor, 7 shiftswap, 10 xornot, 15 none.
REQ-008 SHALL have port: loadctl  out  4  bus-load select; 0-3 regs A-D, 7 flags, 15 none.
REQ-009 SHALL have port: arg_l  out  2  left ALU operand register.
REQ-010 SHALL have port: arg_r  out  3  right ALU operand; 0-3 regs, 6 zero, 7 none.
REQ-011 SHALL have ports: alt  out  1  unit alternate fn; calcfn  out  1  active-low flag update; cin  out  1  ALU carry in.
REQ-012 SHALL have ports: bus_out  out  8  immediate data; bus_oe  out  1  drives bus_out onto main bus.
REQ-013 SHALL have port: halted  out  1  HALT executed.

Function
REQ-014 SHALL implement states IDLE, IMM, EXEC, HALT; instr_ready = 1 only in IDLE and IMM.
REQ-015 IDLE: on accepted byte SHALL latch op/dst/src; op=D -> IMM, op=F -> HALT, else -> EXEC.
REQ-016 IMM: on accepted byte SHALL latch immediate, -> EXEC; no timeout.
REQ-017 EXEC SHALL last exactly one cycle, drive that op's controls, then -> IDLE.
REQ-018 All control outputs SHALL be registered; outside EXEC they SHALL hold idle: outctl=15, loadctl=15, arg_l=0, arg_r=7, alt=0, calcfn=1, cin=0, bus_oe=0, bus_out=0.
REQ-019 EXEC decode (arg_l=dst, arg_r=src, loadctl=dst, calcfn=0 unless stated):
  0 MOV: outctl=5, alt=0, cin=0, arg_l=src, arg_r=6, calcfn=1.
  1 ADD: outctl=5, alt=0, cin=0.  2 ADC: outctl=5, alt=0, cin=fin[0].
  3 SUB: outctl=5, alt=1, cin=1.  4 SBC: outctl=5, alt=1, cin=fin[0].
  5 AND: outctl=6, alt=0.  6 OR: outctl=6, alt=1.  7 XOR: outctl=10, alt=0.
  8 NOT: outctl=10, alt=1, arg_l=src, arg_r=7.
  9 SHL: outctl=7, alt=0, cin=0, arg_r=7.  A RLC: as SHL with cin=fin[0].
  B SWAP: outctl=7, alt=1, arg_r=7, calcfn=1.
  C CMP: as SUB but loadctl=15.
  D LDI: outctl=15, bus_oe=1, bus_out=immediate, loadctl=dst, arg_r=7, calcfn=1.
  E NOP: idle controls.
REQ-020 cin for ADC/SBC/RLC SHALL sample fin[0] at the edge entering EXEC.
REQ-021 Throughput: 2 cycles per 1-byte op, min 3 cycles per LDI.
REQ-022 instr_valid in EXEC/HALT SHALL be ignored; byte not consumed.
REQ-023 HALT SHALL hold idle controls, halted=1, instr_ready=0 until reset.

Reset
REQ-024 rst low SHALL asynchronously force IDLE, idle controls, halted=0, latched op/immediate=0; instr_ready=1 on the first edge after release.
REQ-025 Reset during EXEC or IMM SHALL abort the instruction with no load/flag strobe after assertion.

Structure
REQ-026 Shared package alu_seq_pkg SHALL hold opcode enum, outctl/loadctl/arg_r code constants, state enum.
REQ-027 Combinational decode SHALL be one sub-module alu_op_decode (op, dst, src, imm, carry -> control word).

Verification
REQ-028 Reset, then ADD A,B (0x11) -> next cycle outctl=5, loadctl=0, arg_l=0, arg_r=1, alt=0, cin=0, calcfn=0; then idle.
REQ-029 fin[0]=1, ADC C,D (0x2B) -> cin=1; with fin[0]=0 -> cin=0.
REQ-030 LDI B (0xD4), gap 3 cycles, byte 0x5A -> ready stays 1 in IMM; EXEC bus_oe=1, bus_out=0x5A, loadctl=1, outctl=15.
REQ-031 CMP A,C (0xC2) -> outctl=5, alt=1, cin=1, calcfn=0, loadctl=15.
REQ-032 HALT (0xF0) then valid bytes -> halted=1, ready=0, controls idle; rst low mid-EXEC -> outputs idle immediately.
